// File: rtl/dlx_pkg.sv
// Shared types and encodings for the DLX ALU issue controller.
// ALU operation codes match the ALU's code table; 8 and 9 exist but are never issued.
package dlx_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_RSV8 = 4'd8,
    ALU_RSV9 = 4'd9,
    ALU_SEQ  = 4'd10,
    ALU_SLE  = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SNE  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SUBI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_SLLI  = 6'h14;
  localparam logic [5:0] OPC_SRLI  = 6'h16;
  localparam logic [5:0] OPC_SEQI  = 6'h18;
  localparam logic [5:0] OPC_SNEI  = 6'h19;
  localparam logic [5:0] OPC_SLTI  = 6'h1A;
  localparam logic [5:0] OPC_SLEI  = 6'h1C;

  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SEQ = 6'h28;
  localparam logic [5:0] FN_SNE = 6'h29;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLE = 6'h2C;

endpackage

// File: rtl/dlx_alu_issue_if.sv
// Controller-to-ALU bus: opcode, execute strobe and operands out; registered result and flags back.
interface dlx_alu_if #(
  parameter int XLEN = 32
);
  logic [3:0]      alu_I;
  logic            alu_EX;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [XLEN-1:0] alu_res;
  logic            alu_carry;
  logic            alu_z;

  modport master (
    output alu_I, alu_EX, alu_op1, alu_op2,
    input  alu_res, alu_carry, alu_z
  );

  modport slave (
    input  alu_I, alu_EX, alu_op1, alu_op2,
    output alu_res, alu_carry, alu_z
  );
endinterface

// File: rtl/dlx_regfile.sv
// 32-entry register file: two async read ports, one async debug port, one sync write port.
module dlx_regfile #(
  parameter int XLEN    = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && !(R0_ZERO && waddr == 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1    = (R0_ZERO && raddr1 == 5'd0)    ? '0 : regs_q[raddr1];
  assign rdata2    = (R0_ZERO && raddr2 == 5'd0)    ? '0 : regs_q[raddr2];
  assign dbg_rdata = (R0_ZERO && dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];

endmodule

// File: rtl/dlx_alu_issue.sv
// DLX ALU issue/writeback controller: accept, decode and read operands, issue one strobe, write back.
//   state    | meaning
//   ST_IDLE  | ready for an instruction; decode and latch operands on accept
//   ST_ISSUE | alu_EX high, operands and code held; ALU captures at end of cycle
//   ST_WB    | ALU result valid; write back and pulse done
module dlx_alu_issue
  import dlx_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  dlx_alu_if.master       alu,
  output logic            done,
  output logic [4:0]      done_rd,
  output logic [XLEN-1:0] done_data,
  output logic            done_carry,
  output logic            done_z,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  state_e          state_q, state_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;

  logic [5:0]      opcode, func;
  logic [15:0]     imm;
  alu_op_e         dec_op;
  logic            dec_legal, dec_rtype, dec_zext;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] rdata1, rdata2, dec_op2;

  assign opcode = instr[31:26];
  assign func   = instr[5:0];
  assign imm    = instr[15:0];

  always_comb begin
    dec_op    = ALU_NONE;
    dec_rtype = (opcode == OPC_RTYPE);
    dec_zext  = 1'b0;
    dec_rd    = dec_rtype ? instr[15:11] : instr[20:16];
    if (dec_rtype) begin
      unique case (func)
        FN_ADD:  dec_op = ALU_ADD;
        FN_SUB:  dec_op = ALU_SUB;
        FN_AND:  dec_op = ALU_AND;
        FN_OR:   dec_op = ALU_OR;
        FN_XOR:  dec_op = ALU_XOR;
        FN_SLL:  dec_op = ALU_SLL;
        FN_SRL:  dec_op = ALU_SRL;
        FN_SEQ:  dec_op = ALU_SEQ;
        FN_SLE:  dec_op = ALU_SLE;
        FN_SLT:  dec_op = ALU_SLT;
        FN_SNE:  dec_op = ALU_SNE;
        default: dec_op = ALU_NONE;
      endcase
    end else begin
      unique case (opcode)
        OPC_ADDI: dec_op = ALU_ADD;
        OPC_SUBI: dec_op = ALU_SUB;
        OPC_ANDI: dec_op = ALU_AND;
        OPC_ORI:  dec_op = ALU_OR;
        OPC_XORI: dec_op = ALU_XOR;
        OPC_SLLI: dec_op = ALU_SLL;
        OPC_SRLI: dec_op = ALU_SRL;
        OPC_SEQI: dec_op = ALU_SEQ;
        OPC_SLEI: dec_op = ALU_SLE;
        OPC_SLTI: dec_op = ALU_SLT;
        OPC_SNEI: dec_op = ALU_SNE;
        default:  dec_op = ALU_NONE;
      endcase
      dec_zext = (opcode == OPC_ANDI) || (opcode == OPC_ORI) || (opcode == OPC_XORI);
    end
    dec_legal = (dec_op != ALU_NONE);
    if (dec_rtype)     dec_op2 = rdata2;
    else if (dec_zext) dec_op2 = {{(XLEN-16){1'b0}}, imm};
    else               dec_op2 = {{(XLEN-16){imm[15]}}, imm};
  end

  dlx_regfile #(
    .XLEN    (XLEN),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr1    (instr[25:21]),
    .rdata1    (rdata1),
    .raddr2    (instr[20:16]),
    .rdata2    (rdata2),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .we        (state_q == ST_WB),
    .waddr     (rd_q),
    .wdata     (alu.alu_res)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (dec_legal) begin
            op_d    = dec_op;
            op1_d   = rdata1;
            op2_d   = dec_op2;
            rd_d    = dec_rd;
            state_d = ST_ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= ALU_NONE;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign illegal     = illegal_q;
  assign alu.alu_EX  = (state_q == ST_ISSUE);
  assign alu.alu_I   = (state_q == ST_ISSUE) ? op_q : ALU_NONE;
  assign alu.alu_op1 = op1_q;
  assign alu.alu_op2 = op2_q;

  // Only ADD/SUB produce a meaningful carry.
  assign done       = (state_q == ST_WB);
  assign done_rd    = done ? rd_q : 5'd0;
  assign done_data  = done ? alu.alu_res : '0;
  assign done_z     = done & alu.alu_z;
  assign done_carry = done & alu.alu_carry & ((op_q == ALU_ADD) || (op_q == ALU_SUB));

endmodule

// File: tb/tb_dlx_alu_issue.sv
// Directed bench for dlx_alu_issue: table of instructions with hand-computed results, plus corner sequences.
module tb_dlx_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        done, done_carry, done_z, illegal;
  logic [4:0]  done_rd;
  logic [31:0] done_data, dbg_rdata;
  logic [4:0]  dbg_raddr = '0;

  int n_vec = 0;
  int n_err = 0;

  dlx_alu_if #(.XLEN(32)) bus ();

  dlx_alu_issue #(.XLEN(32), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu(bus), .done(done), .done_rd(done_rd), .done_data(done_data),
    .done_carry(done_carry), .done_z(done_z), .illegal(illegal),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Reference ALU: captures at the edge ending an alu_EX cycle; compares are unsigned.
  always @(posedge clk or negedge rst_n) begin
    logic [32:0] sum;
    logic [31:0] r;
    if (!rst_n) begin
      bus.alu_res <= '0; bus.alu_carry <= 1'b0; bus.alu_z <= 1'b0;
    end else if (bus.alu_EX) begin
      sum = 33'd0;
      r   = 32'd0;
      case (bus.alu_I)
        4'd1:  begin sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2}; r = sum[31:0]; end
        4'd2:  begin r = bus.alu_op1 - bus.alu_op2; sum[32] = (bus.alu_op1 < bus.alu_op2); end
        4'd3:  r = bus.alu_op1 & bus.alu_op2;
        4'd4:  r = bus.alu_op1 | bus.alu_op2;
        4'd5:  r = bus.alu_op1 ^ bus.alu_op2;
        4'd6:  r = bus.alu_op1 << bus.alu_op2[2:0];
        4'd7:  r = bus.alu_op1 >> bus.alu_op2[2:0];
        4'd10: r = {31'd0, bus.alu_op1 == bus.alu_op2};
        4'd11: r = {31'd0, bus.alu_op1 <= bus.alu_op2};
        4'd12: r = {31'd0, bus.alu_op1 <  bus.alu_op2};
        4'd13: r = {31'd0, bus.alu_op1 != bus.alu_op2};
        default: r = 32'd0;
      endcase
      bus.alu_res   <= r;
      bus.alu_carry <= sum[32];
      bus.alu_z     <= (r == 32'd0);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        carry;
    logic        z;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] rt(input logic [4:0] rs1, rs2, rd, input logic [5:0] fn);
    return {6'h00, rs1, rs2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] opc, input logic [4:0] rs1, rd, input logic [15:0] im);
    return {opc, rs1, rd, im};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_raddr = a;
    #1;
    v = dbg_rdata;
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] rv;
    n_vec++;
    @(negedge clk);
    chk({v.name, " ready"}, {31'd0, instr_ready}, 32'd1);
    instr = v.instr; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({v.name, " issue EX"}, {31'd0, bus.alu_EX}, 32'd1);
    chk({v.name, " issue I"}, {28'd0, bus.alu_I}, {28'd0, v.op});
    chk({v.name, " op1"}, bus.alu_op1, v.op1);
    chk({v.name, " op2"}, bus.alu_op2, v.op2);
    chk({v.name, " done early"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk({v.name, " EX width"}, {31'd0, bus.alu_EX}, 32'd0);
    chk({v.name, " I idle"}, {28'd0, bus.alu_I}, 32'd0);
    chk({v.name, " done"}, {31'd0, done}, 32'd1);
    chk({v.name, " done_rd"}, {27'd0, done_rd}, {27'd0, v.rd});
    chk({v.name, " done_data"}, done_data, v.res);
    chk({v.name, " done_carry"}, {31'd0, done_carry}, {31'd0, v.carry});
    chk({v.name, " done_z"}, {31'd0, done_z}, {31'd0, v.z});
    @(posedge clk); #1;
    chk({v.name, " done pulse"}, {31'd0, done}, 32'd0);
    rd_reg(v.rd, rv);
    chk({v.name, " regfile"}, rv, (v.rd == 5'd0) ? 32'd0 : v.res);
  endtask

  task automatic illegal_seq(input string nm, input logic [31:0] w);
    logic [31:0] rv;
    n_vec++;
    @(negedge clk);
    instr = w; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({nm, " illegal"}, {31'd0, illegal}, 32'd1);
    chk({nm, " no EX"}, {31'd0, bus.alu_EX}, 32'd0);
    chk({nm, " ready"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk({nm, " illegal pulse"}, {31'd0, illegal}, 32'd0);
    chk({nm, " no done"}, {31'd0, done}, 32'd0);
    rd_reg(5'd1, rv);
    chk({nm, " r1 kept"}, rv, 32'hFFFF_FFFF);
    rd_reg(5'd3, rv);
    chk({nm, " r3 kept"}, rv, 32'h0000_8000);
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] b2b [4];
    int acc [4];
    int idx, cyc;

    vecs[0]  = '{"ADDI r1",  it(6'h08, 5'd0, 5'd1, 16'hFFFF),  4'd1,  32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b0, 1'b0};
    vecs[1]  = '{"ADD r2",   rt(5'd1, 5'd1, 5'd2, 6'h20),      4'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd2,  1'b1, 1'b0};
    vecs[2]  = '{"ORI r3",   it(6'h0D, 5'd0, 5'd3, 16'h8000),  4'd4,  32'h0,         32'h0000_8000, 32'h0000_8000, 5'd3,  1'b0, 1'b0};
    vecs[3]  = '{"SUB r4",   rt(5'd3, 5'd3, 5'd4, 6'h22),      4'd2,  32'h0000_8000, 32'h0000_8000, 32'h0,         5'd4,  1'b0, 1'b1};
    vecs[4]  = '{"SLLI r5",  it(6'h14, 5'd3, 5'd5, 16'd9),     4'd6,  32'h0000_8000, 32'h9,         32'h0001_0000, 5'd5,  1'b0, 1'b0};
    vecs[5]  = '{"SLT r6",   rt(5'd0, 5'd3, 5'd6, 6'h2A),      4'd12, 32'h0,         32'h0000_8000, 32'h1,         5'd6,  1'b0, 1'b0};
    vecs[6]  = '{"SLE r7",   rt(5'd3, 5'd0, 5'd7, 6'h2C),      4'd11, 32'h0000_8000, 32'h0,         32'h0,         5'd7,  1'b0, 1'b1};
    vecs[7]  = '{"ADDI r0",  it(6'h08, 5'd0, 5'd0, 16'd5),     4'd1,  32'h0,         32'h5,         32'h5,         5'd0,  1'b0, 1'b0};
    vecs[8]  = '{"XORI r8",  it(6'h0E, 5'd1, 5'd8, 16'hFFFF),  4'd5,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 5'd8,  1'b0, 1'b0};
    vecs[9]  = '{"ANDI r9",  it(6'h0C, 5'd1, 5'd9, 16'h00F0),  4'd3,  32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_00F0, 5'd9,  1'b0, 1'b0};
    vecs[10] = '{"SRLI r10", it(6'h16, 5'd1, 5'd10, 16'd4),    4'd7,  32'hFFFF_FFFF, 32'h4,         32'h0FFF_FFFF, 5'd10, 1'b0, 1'b0};
    vecs[11] = '{"SUBI r11", it(6'h0A, 5'd3, 5'd11, 16'd1),    4'd2,  32'h0000_8000, 32'h1,         32'h0000_7FFF, 5'd11, 1'b0, 1'b0};
    vecs[12] = '{"SEQI r12", it(6'h18, 5'd3, 5'd12, 16'h8000), 4'd10, 32'h0000_8000, 32'hFFFF_8000, 32'h0,         5'd12, 1'b0, 1'b1};
    vecs[13] = '{"SNE r13",  rt(5'd1, 5'd2, 5'd13, 6'h29),     4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         5'd13, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    for (int i = 0; i < 32; i++) begin
      rd_reg(i[4:0], rv);
      chk($sformatf("reset r%0d", i), rv, 32'd0);
    end
    chk("reset ready", {31'd0, instr_ready}, 32'd1);
    chk("reset EX", {31'd0, bus.alu_EX}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);

    for (int i = 0; i < 14; i++) apply(vecs[i]);

    illegal_seq("opc3F", 32'hFC22_0001);
    illegal_seq("func21", rt(5'd1, 5'd1, 5'd20, 6'h21));

    // Back-to-back with instr_valid held high: accepts must land every 3 cycles.
    n_vec++;
    b2b[0] = it(6'h08, 5'd0, 5'd14, 16'd1);
    b2b[1] = it(6'h08, 5'd14, 5'd15, 16'd2);
    b2b[2] = rt(5'd15, 5'd14, 5'd16, 6'h20);
    b2b[3] = rt(5'd16, 5'd16, 5'd17, 6'h20);
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk);
      instr = b2b[idx];
      instr_valid = 1'b1;
      if (instr_ready) begin
        acc[idx] = cyc;
        idx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("b2b accepted", idx, 4);
    if (idx == 4) begin
      for (int i = 0; i < 3; i++) chk($sformatf("b2b spacing %0d", i), acc[i+1] - acc[i], 3);
    end
    repeat (3) @(posedge clk); #1;
    rd_reg(5'd15, rv); chk("b2b r15", rv, 32'd3);
    rd_reg(5'd16, rv); chk("b2b r16", rv, 32'd4);
    rd_reg(5'd17, rv); chk("b2b r17", rv, 32'd8);

    // Reset while in ISSUE: instruction abandoned, everything cleared.
    n_vec++;
    @(negedge clk);
    instr = it(6'h08, 5'd0, 5'd18, 16'd7); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rst issue EX", {31'd0, bus.alu_EX}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst ready", {31'd0, instr_ready}, 32'd1);
    chk("rst EX", {31'd0, bus.alu_EX}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst done", {31'd0, done}, 32'd0);
    chk("post rst ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      rd_reg(i[4:0], rv);
      chk($sformatf("post rst r%0d", i), rv, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
